// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types and default geometry for the 512x44 single-port SRAM controller.
package ct_f_spsram_ctrl_pkg;

  localparam int unsigned SPSRAM_ADDR_WIDTH = 9;
  localparam int unsigned SPSRAM_DATA_WIDTH = 44;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } spsram_state_e;

endpackage : ct_f_spsram_ctrl_pkg

// File: rtl/ct_f_spsram_init_seq.sv
// Init sweep sequencer: walks every SRAM address once after reset/flush, then parks in RUN.
module ct_f_spsram_init_seq
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = SPSRAM_ADDR_WIDTH,
  parameter bit          INIT_ON_RST = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush_req,
  output logic                  init_active,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  spsram_state_e         state_q;
  logic [ADDR_WIDTH-1:0] init_cnt;

  // State and sweep counter; the counter wraps to 0 naturally on the last write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (INIT_ON_RST) begin
        state_q <= INIT;
      end else begin
        state_q <= RUN;
      end
      init_cnt <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (flush_req) begin
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
            if (init_cnt == LAST_ADDR) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_req) begin
            state_q  <= INIT;
            init_cnt <= '0;
          end
        end
        default: begin
          state_q  <= INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  // Reset masks the state so nothing reaches the SRAM while RST is high.
  assign init_active = ~RST & (state_q == INIT);
  assign init_done   = ~RST & (state_q == RUN);
  assign init_addr   = init_cnt;

endmodule : ct_f_spsram_init_seq

// File: rtl/ct_f_spsram_512x44_ctrl.sv
// Access controller for the 512x44 single-port SRAM wrapper.
// Optional macro CT_F_SPSRAM_RDHOLD_EN: registered, held read data with latency 2.
module ct_f_spsram_512x44_ctrl
  import ct_f_spsram_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = SPSRAM_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH  = SPSRAM_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL    = '0,
  parameter bit                    INIT_ON_RST = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic                  init_active;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  accept;
  logic                  rd_p1;

  ct_f_spsram_init_seq #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INIT_ON_RST (INIT_ON_RST)
  ) u_init_seq (
    .CLK         (CLK),
    .RST         (RST),
    .flush_req   (flush_req),
    .init_active (init_active),
    .init_addr   (init_addr),
    .init_done   (init_done)
  );

  // Flush has priority over a client request in the same cycle.
  assign req_rdy = init_done & ~flush_req;
  assign accept  = req_vld & req_rdy;

  // SRAM drive mux: reset idle, init sweep write, or client access; polarity inverted here.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (RST) begin
      sram_cen = 1'b1;
    end else if (init_active) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_addr;
      sram_d    = INIT_VAL;
    end else if (accept) begin
      sram_cen  = 1'b0;
      sram_a    = req_addr;
      sram_d    = req_wdata;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_wmask;
      end else begin
        sram_gwen = 1'b1;
        sram_wen  = '1;
      end
    end
  end

`ifdef CT_F_SPSRAM_RDHOLD_EN
  logic                  rd_p2;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Two-stage read pipe; data captured from Q one cycle before the valid pulse and held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_p1   <= 1'b0;
      rd_p2   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_p1 <= accept & ~req_wr;
      rd_p2 <= rd_p1;
      if (rd_p1) begin
        rdata_q <= sram_q;
      end
    end
  end

  assign rsp_vld  = rd_p2 & ~RST;
  assign rsp_data = rdata_q;
`else
  // Single-stage read pipe; Q is forwarded straight to the client.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_p1 <= 1'b0;
    end else begin
      rd_p1 <= accept & ~req_wr;
    end
  end

  assign rsp_vld  = rd_p1 & ~RST;
  assign rsp_data = sram_q;
`endif

endmodule : ct_f_spsram_512x44_ctrl
